// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
// Holds FSM state encodings, requester IDs and default widths.
package ram_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef logic [0:0] state_t;
  localparam state_t INIT = 1'b0;
  localparam state_t ARB  = 1'b1;

  typedef logic req_id_t;
  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin picker. The grant is combinational from req and the
// priority pointer; the pointer moves only when a grant is issued.
module ram_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Requester that wins a tie on the next contested cycle.
  req_id_t prio_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_q == REQ_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_A;
    end else if (gnt[0]) begin
      prio_q <= REQ_B;
    end else if (gnt[1]) begin
      prio_q <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B with round-robin
// arbitration, after sweeping every location to INIT_VAL following reset.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned          DATA_W   = DATA_W_DEF,
  parameter int unsigned          ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              init_done_q;
  logic              rd_pending_q;
  req_id_t           rd_owner_q;

  logic [1:0]        gnt;
  logic              any_gnt;
  req_id_t           win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              we_core;
  logic [ADDR_W-1:0] waddr_core;
  logic [ADDR_W-1:0] raddr_core;
  logic [DATA_W-1:0] data_core;

  ram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_req, a_req}),
    .en    (state_q == ARB),
    .gnt   (gnt)
  );

  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign any_gnt   = |gnt;
  assign win_id    = gnt[1] ? REQ_B : REQ_A;
  assign win_we    = gnt[1] ? b_we : a_we;
  assign win_addr  = gnt[1] ? b_addr : a_addr;
  assign win_wdata = gnt[1] ? b_wdata : a_wdata;

  // Idle cycles fall through to the held values so both addresses stay put.
  always_comb begin
    we_core    = 1'b0;
    waddr_core = waddr_q;
    raddr_core = raddr_q;
    data_core  = wdata_q;
    if (state_q == INIT) begin
      we_core    = 1'b1;
      waddr_core = cnt_q;
      data_core  = INIT_VAL;
    end else if (any_gnt) begin
      if (win_we) begin
        we_core    = 1'b1;
        waddr_core = win_addr;
        data_core  = win_wdata;
      end else begin
        raddr_core = win_addr;
      end
    end
  end

  // INIT drives a write combinationally; mask it so reset shows quiet RAM ports.
  assign ram_write_enable = rst_n & we_core;
  assign ram_data         = rst_n ? data_core : '0;
  assign ram_write_addr   = waddr_core;
  assign ram_read_addr    = raddr_core;
  assign init_done        = init_done_q;

  assign a_rvalid = rd_pending_q && (rd_owner_q == REQ_A);
  assign b_rvalid = rd_pending_q && (rd_owner_q == REQ_B);
  assign a_rdata  = a_rvalid ? ram_q : '0;
  assign b_rdata  = b_rvalid ? ram_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      wdata_q      <= '0;
      init_done_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= REQ_A;
    end else begin
      waddr_q      <= waddr_core;
      raddr_q      <= raddr_core;
      wdata_q      <= data_core;
      rd_pending_q <= any_gnt && !win_we;
      if (any_gnt) begin
        rd_owner_q <= win_id;
      end
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_q     <= ARB;
          init_done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed ops push expected read data,
// a negedge monitor pops and compares whenever an rvalid appears.
module tb_ram_port_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [DW-1:0] ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic          ram_write_enable, init_done;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .INIT_VAL (8'h00)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .a_req            (a_req),
    .a_we             (a_we),
    .a_addr           (a_addr),
    .a_wdata          (a_wdata),
    .a_gnt            (a_gnt),
    .a_rvalid         (a_rvalid),
    .a_rdata          (a_rdata),
    .b_req            (b_req),
    .b_we             (b_we),
    .b_addr           (b_addr),
    .b_wdata          (b_wdata),
    .b_gnt            (b_gnt),
    .b_rvalid         (b_rvalid),
    .b_rdata          (b_rdata),
    .ram_data         (ram_data),
    .ram_write_addr   (ram_write_addr),
    .ram_read_addr    (ram_read_addr),
    .ram_write_enable (ram_write_enable),
    .ram_q            (ram_q),
    .init_done        (init_done)
  );

  // Behavioural single-port RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } op_t;

  op_t           a_ops[$];
  op_t           b_ops[$];
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  bit            gnt_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic [DW-1:0] ex);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wd; o.exp = ex;
    return o;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, ram_write_enable, 0);
    chk({tag, "_waddr"}, ram_write_addr, 0);
    chk({tag, "_raddr"}, ram_read_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_gnt"}, {a_gnt, b_gnt}, 0);
    chk({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
    chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask

  // Releases reset at a negedge and follows the sweep; abort_at >= 0 pulls reset there.
  task automatic release_and_sweep(input int abort_at);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("sweep_we", ram_write_enable, 1);
      chk("sweep_addr", ram_write_addr, i);
      chk("sweep_data", ram_data, 8'h00);
      chk("sweep_no_gnt", {a_gnt, b_gnt}, 0);
      chk("sweep_init_done", init_done, 0);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_sweep_reset");
        return;
      end
      @(negedge clk);
    end
    #1;
    chk("init_done", init_done, 1);
    chk("post_sweep_we", ram_write_enable, 0);
    chk("post_sweep_waddr_hold", ram_write_addr, DEPTH - 1);
  endtask

  // Must be entered just after a negedge; each queued op holds req until granted.
  task automatic run_ops(input int max_cycles);
    int cyc = 0;
    while ((a_ops.size() != 0 || b_ops.size() != 0) && cyc < max_cycles) begin
      if (a_ops.size() != 0) begin
        a_req = 1'b1; a_we = a_ops[0].we; a_addr = a_ops[0].addr; a_wdata = a_ops[0].wdata;
      end else begin
        a_req = 1'b0;
      end
      if (b_ops.size() != 0) begin
        b_req = 1'b1; b_we = b_ops[0].we; b_addr = b_ops[0].addr; b_wdata = b_ops[0].wdata;
      end else begin
        b_req = 1'b0;
      end
      #1;
      chk("one_hot_gnt", a_gnt & b_gnt, 0);
      chk("a_gnt_without_req", a_gnt & ~a_req, 0);
      chk("b_gnt_without_req", b_gnt & ~b_req, 0);
      if (a_gnt && a_ops.size() != 0) begin
        if (!a_ops[0].we) exp_a.push_back(a_ops[0].exp);
        gnt_log.push_back(1'b0);
        void'(a_ops.pop_front());
      end else if (b_gnt && b_ops.size() != 0) begin
        if (!b_ops[0].we) exp_b.push_back(b_ops[0].exp);
        gnt_log.push_back(1'b1);
        void'(b_ops.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    chk("ops_left_at_timeout", a_ops.size() + b_ops.size(), 0);
    a_ops.delete();
    b_ops.delete();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // pattern bit i is the requester expected on the i-th grant (0 = A, 1 = B).
  task automatic check_log(input string name, input int n, input logic [7:0] pattern);
    chk({name, "_count"}, gnt_log.size(), n);
    for (int i = 0; i < n && i < gnt_log.size(); i++) begin
      chk({name, "_order"}, gnt_log[i], pattern[i]);
    end
    gnt_log.delete();
  endtask

  // Monitor: every rvalid must match the oldest expectation for its owner.
  initial begin
    forever begin
      @(negedge clk);
      if (a_rvalid) begin
        if (exp_a.size() == 0) chk("a_rvalid_unexpected", a_rvalid, 0);
        else chk("a_rdata", a_rdata, exp_a.pop_front());
      end else begin
        chk("a_rdata_idle_zero", a_rdata, 0);
      end
      if (b_rvalid) begin
        if (exp_b.size() == 0) chk("b_rvalid_unexpected", b_rvalid, 0);
        else chk("b_rdata", b_rdata, exp_b.pop_front());
      end else begin
        chk("b_rdata_idle_zero", b_rdata, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Sweep aborted at address 30, then a full restart from 0.
    release_and_sweep(30);
    release_and_sweep(-1);

    // Location 5 holds the sweep value.
    a_ops.push_back(mk(1'b0, 6'd5, 8'h00, 8'h00));
    run_ops(20);
    check_log("read5", 1, 8'b0);

    // Write then read back the same address on consecutive grants.
    a_ops.push_back(mk(1'b1, 6'd3, 8'hA5, 8'h00));
    a_ops.push_back(mk(1'b0, 6'd3, 8'h00, 8'hA5));
    run_ops(20);
    check_log("a_wr_rd", 2, 8'b00);

    b_ops.push_back(mk(1'b1, 6'd2, 8'h22, 8'h00));
    run_ops(20);
    check_log("b_wr", 1, 8'b1);

    // Last grant went to B, so contention starts with A and then alternates.
    a_ops.push_back(mk(1'b1, 6'd1, 8'h11, 8'h00));
    a_ops.push_back(mk(1'b0, 6'd1, 8'h00, 8'h11));
    a_ops.push_back(mk(1'b0, 6'd1, 8'h00, 8'h11));
    b_ops.push_back(mk(1'b0, 6'd2, 8'h00, 8'h22));
    b_ops.push_back(mk(1'b0, 6'd2, 8'h00, 8'h22));
    b_ops.push_back(mk(1'b0, 6'd2, 8'h00, 8'h22));
    run_ops(20);
    check_log("alternate", 6, 8'b0010_1010);
    repeat (3) @(negedge clk);

    // Reset in the cycle after a read grant: the rvalid must never appear.
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3;
    #1;
    chk("rd_before_reset_gnt", a_gnt, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    check_reset_outputs("reset_after_read");

    // Both requesters pend through the sweep; A wins first once arbitration opens.
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    release_and_sweep(-1);
    a_ops.push_back(mk(1'b0, 6'd1, 8'h00, 8'h00));
    b_ops.push_back(mk(1'b0, 6'd2, 8'h00, 8'h00));
    run_ops(10);
    check_log("init_pending", 2, 8'b10);

    repeat (4) @(negedge clk);
    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one ram_single_port instance (one access per clock) between two requesters, A and B.
- Each requester uses a req/gnt handshake; arbitration is round-robin.
- After reset the block sweeps the whole RAM to a known value, then opens arbitration.
- Sits directly in front of the RAM and owns all of its ports.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
- INIT_VAL, 8'h00, value written to every location during the post-reset sweep.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A access request; held until granted.
- a_we  in  1  A access is a write (1) or a read (0).
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A access accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_data  out  DATA_W  to RAM data.
- ram_write_addr  out  ADDR_W  to RAM write_addr.
- ram_read_addr  out  ADDR_W  to RAM read_addr.
- ram_write_enable  out  1  to RAM write_enable.
- ram_q  in  DATA_W  from RAM q; registered read, valid in the cycle after the read address is sampled.
- init_done  out  1  high once the sweep has finished.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write_enable, init_done = 0.
  - a_rdata, b_rdata, ram_data = 0.
  - RAM addresses = 0.
  - Sweep counter = 0.
  - Round-robin pointer favours A.
  - FSM = INIT.
- FSM states: INIT, ARB.
- INIT:
  - ram_write_enable = 1, ram_write_addr = counter, ram_data = INIT_VAL.
  - Counter increments each cycle.
  - After the write of address 2**ADDR_W-1, go to ARB and set init_done = 1 from the next cycle.
  - The sweep takes exactly 2**ADDR_W cycles.
  - No grants are issued in INIT; requests stay pending.
- ARB:
  - gnt is combinational from req and the pointer, in the same cycle. At most one gnt is high per cycle.
  - Only one requester asserting req: it is granted.
  - Both asserting req: grant the one not granted most recently.
  - The pointer updates only on a grant. Idle cycles leave it unchanged.
- Granted write:
  - ram_write_enable = 1 with ram_write_addr and ram_data taken from the winner.
  - Data is written at the end of the grant cycle.
- Granted read:
  - ram_write_enable = 0, ram_read_addr = winner address.
  - Owner ID is registered at the edge.
  - In the next cycle the owner's rvalid = 1 and its rdata = ram_q.
  - rdata is 0 whenever that requester's rvalid = 0.
- Idle cycle: ram_write_enable = 0; both addresses hold their previous values.
- Back-to-back: a new grant may be issued in the same cycle as rvalid for the previous read. Throughput is one access per cycle.
- Write then read of the same address on consecutive grants returns the new data.
- Requester rules:
  - req must stay high with stable we/addr/wdata until gnt.
  - A requester may drop req without being granted; no access occurs.
- Reset mid-operation (rst_n low at any point):
  - All outputs return to their reset values immediately.
  - Any in-flight rvalid is dropped.
  - The sweep restarts from address 0.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {INIT, ARB};
  - typedef req_id_t (1 bit: 0 = A, 1 = B);
  - default width constants DATA_W_DEF = 8, ADDR_W_DEF = 6.
- Sub-module ram_rr_arb2: 2-way round-robin picker.
  - Inputs: clk, rst_n, req[1:0], en.
  - Outputs: gnt[1:0], owns the pointer.
  - Instantiated once, with en = (state == ARB).

Test Plan:
- Reset, then hold a_req = b_req = 0 -> ram_write_enable high for exactly 64 cycles, addresses 0..63 with data 8'h00, then init_done = 1. A read of address 5 then returns 8'h00.
- A writes 8'hA5 to address 3, then reads address 3 -> a_gnt in each request cycle, a_rvalid one cycle after the read grant with a_rdata = 8'hA5, b_rvalid stays 0.
- A and B request continuously (A reads address 1, B reads address 2 after writing 8'h11 and 8'h22) -> grants alternate A, B, A, B. Each rvalid goes only to its owner with the correct data, and no cycle has both gnt high.
- Requests asserted during INIT -> no gnt until init_done. The first grant goes to A when both are pending.
- rst_n pulsed low mid-sweep (at address 30) and again the cycle after a read grant -> outputs go to zero immediately, no rvalid is issued, and the sweep restarts at address 0 with a full 64 cycles.
